// File: rtl/fifo_flags.sv
// ============================================================================
// fifo_flags
// ----------------------------------------------------------------------------
// Single-clock synchronous FIFO with first-word-fall-through reads. It provides
// a registered occupancy count, programmable almost-full and almost-empty
// watermarks, a synchronous flush, and defined read-while-full behaviour.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   : sticky overflow / underflow flags, cleared by err_clr or reset.
//   undefined : overflow / underflow are tied low and err_clr is ignored.
//
// Parameters
//   DATA_WIDTH : width of each stored word in bits
//   ADDR_WIDTH : log2 of depth (depth = 2**ADDR_WIDTH, ADDR_WIDTH >= 1)
//   AF_LEVEL   : almost_full  when count >= AF_LEVEL (1..depth)
//   AE_LEVEL   : almost_empty when count <= AE_LEVEL (0..depth-1)
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   flush        in   synchronous clear of pointers/count (array untouched)
//   wr           in   write request
//   w_data       in   write data [DATA_WIDTH]
//   rd           in   read (pop) request
//   r_data       out  head-of-FIFO word, valid while empty = 0
//   empty        out  FIFO holds 0 words
//   full         out  FIFO holds depth words
//   almost_empty out  count <= AE_LEVEL
//   almost_full  out  count >= AF_LEVEL
//   count        out  occupancy 0..depth [ADDR_WIDTH+1]
//   overflow     out  sticky dropped-write flag (optional feature)
//   underflow    out  sticky read-while-empty flag (optional feature)
//   err_clr      in   clears overflow / underflow
// ============================================================================
module fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_wr_accept;
    logic w_rd_accept;

    // ------------------------------------------------------------------------
    // Status flags are plain compares on the registered count, so they follow
    // an accepted operation by one cycle.
    // ------------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= AE_C);
    assign almost_full  = (r_count >= AF_C);
    assign count        = r_count;

    // A write into a full FIFO is still accepted when a pop happens in the
    // same cycle: the slot being freed is the one written. A pop from an
    // empty FIFO is always ignored, even alongside a write.
    assign w_wr_accept = wr && (!w_full || rd);
    assign w_rd_accept = rd && !w_empty;

    // ------------------------------------------------------------------------
    // Storage: no reset, written only on an accepted write. Flush and reset
    // leave the contents alone, only the pointers move.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_accept && reset_n && !flush) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    // First-word-fall-through: the head word is read straight from the array.
    assign r_data = r_mem[r_rptr];

    // ------------------------------------------------------------------------
    // Pointers and occupancy counter. Flush behaves like reset here and wins
    // over any wr/rd in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Simultaneous accepted write and read leave the count alone,
            // which also covers the read-while-full case.
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional sticky error flags
    // ------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_event;
    logic w_unf_event;

    assign w_ovf_event = wr && w_full && !rd;
    assign w_unf_event = rd && w_empty;

    // A set event in the same cycle as err_clr keeps the flag set. Flush is
    // deliberately not part of this block so error history survives it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !err_clr) || w_ovf_event;
            r_underflow <= (r_underflow && !err_clr) || w_unf_event;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Error logic is not built; err_clr has no function in this build.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;

    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// ============================================================================
// tb_fifo_flags
// ----------------------------------------------------------------------------
// Directed bench for fifo_flags with default parameters (8-bit data, depth 8,
// almost_full at >= 7, almost_empty at <= 1). Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
// ============================================================================
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    fifo_flags #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_status(input string tag, input logic [3:0] exp_count);
        check({tag, ".count"}, count, exp_count);
        check({tag, ".empty"}, empty, exp_count == 0);
        check({tag, ".full"},  full,  exp_count == 8);
        check({tag, ".ae"},    almost_empty, exp_count <= 1);
        check({tag, ".af"},    almost_full,  exp_count >= 7);
    endtask

    initial begin
        logic [7:0] exp_drain [8];

        reset_n = 1'b0;
        flush   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = 8'h00;
        err_clr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // ---- reset state ----
        check_status("reset", 4'd0);
        check("reset.ovf", overflow, 1'b0);
        check("reset.unf", underflow, 1'b0);

        // ---- 1: fill with F0..F7, then drain in order ----
        for (int i = 0; i < 8; i++) begin
            wr     = 1'b1;
            w_data = 8'hF0 + 8'(i);
            tick();
            check_status("fill", 4'(i + 1));
            check("fill.head", r_data, 8'hF0);
        end
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("drain.data", r_data, 8'hF0 + 8'(i));
            rd = 1'b1;
            tick();
            check_status("drain", 4'(7 - i));
        end
        rd = 1'b0;

        // ---- 2: write to full FIFO is dropped ----
        for (int i = 0; i < 8; i++) begin
            wr     = 1'b1;
            w_data = 8'hF0 + 8'(i);
            tick();
        end
        w_data = 8'hAA;
        tick();
        wr = 1'b0;
        check_status("ovf", 4'd8);
        check("ovf.head", r_data, 8'hF0);
        check("ovf.flag", overflow, ERR_EN);
        tick();
        check("ovf.sticky", overflow, ERR_EN);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf.clr", overflow, 1'b0);

        // ---- 3: read+write while full keeps count at depth ----
        for (int i = 0; i < 3; i++) begin
            wr     = 1'b1;
            rd     = 1'b1;
            w_data = 8'h10 + 8'(i);
            tick();
            check("rwfull.count", count, 4'd8);
            check("rwfull.full", full, 1'b1);
        end
        wr = 1'b0;
        rd = 1'b0;
        exp_drain = '{8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'h10, 8'h11, 8'h12};
        for (int i = 0; i < 8; i++) begin
            check("rwfull.data", r_data, exp_drain[i]);
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        check_status("rwfull.end", 4'd0);

        // ---- 4: read on empty with simultaneous write ----
        wr     = 1'b1;
        rd     = 1'b1;
        w_data = 8'h55;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        check_status("unf", 4'd1);
        check("unf.data", r_data, 8'h55);
        check("unf.flag", underflow, ERR_EN);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unf.clr", underflow, 1'b0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_status("unf.pop", 4'd0);

        // ---- 5: pointer wrap with alternating write/read ----
        for (int k = 0; k < 10; k++) begin
            wr     = 1'b1;
            w_data = 8'h60 + 8'(k);
            tick();
            wr = 1'b0;
            check("wrap.cnt1", count, 4'd1);
            check("wrap.data", r_data, 8'h60 + 8'(k));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            check("wrap.cnt0", count, 4'd0);
        end

        // ---- 6: flush beats a same-cycle write; reset mid-fill ----
        for (int i = 0; i < 5; i++) begin
            wr     = 1'b1;
            w_data = 8'h30 + 8'(i);
            tick();
        end
        check("flush.pre", count, 4'd5);
        flush  = 1'b1;
        w_data = 8'hEE;
        tick();
        flush = 1'b0;
        wr    = 1'b0;
        check_status("flush", 4'd0);
        tick();
        check("flush.hold", count, 4'd0);

        for (int i = 0; i < 3; i++) begin
            wr     = 1'b1;
            w_data = 8'h40 + 8'(i);
            tick();
        end
        wr = 1'b0;
        check("rst.pre", count, 4'd3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_status("rst", 4'd0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.unf", underflow, 1'b0);

        // FIFO still works after reset and starts from a clean head
        wr     = 1'b1;
        w_data = 8'h77;
        tick();
        wr = 1'b0;
        check_status("post", 4'd1);
        check("post.data", r_data, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised synchronous FIFO, successor to the basic FIFO.
- Adds a registered occupancy count, programmable almost-full/almost-empty watermarks, a synchronous flush, and defined read-while-full behaviour.
- Reads are first-word-fall-through: the head word is always visible on r_data.
- Used as the general buffering element between producer/consumer blocks in the same clock domain (UART, SPI, streaming datapaths).

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- ADDR_WIDTH, 3, log2 of depth; depth = 2**ADDR_WIDTH (minimum 1).
- AF_LEVEL, 2**ADDR_WIDTH-1, almost_full asserts when count >= AF_LEVEL (range 1..depth).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (range 0..depth-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of contents; data array is not cleared.
- wr  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- rd  in  1  read (pop) request.
- r_data  out  DATA_WIDTH  head-of-FIFO word, valid while empty=0.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds depth words.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- overflow  out  1  sticky error flag, see Optional Feature.
- underflow  out  1  sticky error flag, see Optional Feature.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Storage: depth x DATA_WIDTH register array.
  - Write pointer and read pointer are ADDR_WIDTH bits and wrap naturally modulo depth.
  - count is a separate registered counter.
- Reset (reset_n=0 at rising edge):
  - Pointers=0, count=0.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0.
  - Array contents are not reset.
- flush=1: same effect as reset on pointers, count and flags (overflow/underflow excepted). Higher priority than wr/rd in the same cycle.
- Write accepted when wr=1 and (full=0 or rd=1):
  - mem[wptr] <= w_data.
  - wptr increments.
- Read accepted when rd=1 and empty=0:
  - rptr increments.
- Priority cases:
  - wr=1 with full=1 and rd=0: write dropped; state unchanged.
  - rd=1 with empty=1: read ignored, even if wr=1 that cycle. The write proceeds, and the word appears on r_data the next cycle.
  - wr=1, rd=1, full=1: both accepted; count stays at depth; the oldest word is popped and the new word is stored.
  - wr=1, rd=1, 0<count<depth: both accepted; count unchanged.
- count:
  - +1 on a write-only cycle, -1 on a read-only cycle, unchanged otherwise.
  - Never leaves 0..depth.
- Flag timing:
  - empty, full, almost_* are derived from the registered count (combinational compare).
  - They therefore update 1 cycle after the accepted operation.
- r_data = mem[rptr], combinational from the array.
  - Undefined (not checked) while empty=1.
- Latency: a write at edge N is visible on r_data after edge N when the FIFO was empty (0-cycle fall-through after the write edge).

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any dropped write (wr=1, full=1, rd=0).
  - underflow sets on rd=1 while empty=1.
  - Both are sticky until err_clr=1 or reset. A set event and err_clr in the same cycle leaves the flag set.
  - flush does not clear the flags.
- Undefined:
  - overflow and underflow are tied 0.
  - err_clr is ignored; no error logic is synthesised.

Test Plan:
1. Reset, then write 8 words 8'hF0..8'hF7 (ADDR_WIDTH=3):
   - count steps to 8, full=1.
   - almost_full=1 from count=7.
   - Then read 8 -> r_data F0..F7 in order, empty=1, count=0.
2. Fill to full, then wr=1 with w_data=8'hAA and rd=0 -> count stays 8, contents unchanged. With FIFO_ERR_FLAGS_EN, overflow=1 until err_clr.
3. Full FIFO, wr=1 and rd=1 for 3 cycles with 8'h10..8'h12:
   - count=8 throughout.
   - Subsequent drain yields F3..F7, 10, 11, 12.
4. Empty FIFO, rd=1 with wr=1 and w_data=8'h55:
   - Next cycle count=1, empty=0, r_data=8'h55.
   - With macro: underflow=1.
5. Pointer wrap: 20 cycles of interleaved single writes and reads with incrementing data -> every read returns the matching write value; count oscillates 0/1.
6. Write 5 words, assert flush together with wr=1 -> count=0, empty=1, almost_empty=1 next cycle. Assert reset_n=0 mid-fill -> same reset values.
